// File: rtl/frame_writer.sv
// Packs an 8-bit pixel stream into 16-bit words and writes each frame into the back bank
// of a double-buffered frame store, swapping banks when a frame completes.
// Optional: define FRAME_WRITER_SOF_RESYNC_EN so that in_sof in mid-frame restarts the frame.
module frame_writer #(
    parameter int MEM_ADDR_WIDTH = 24,
    parameter int FRAME_WORDS    = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic                      in_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]               mem_wdata,
    output logic                      mem_we,
    input  logic                      mem_ack,
    output logic                      frame_done,
    output logic                      rd_bank
);

    localparam int IDX_W = MEM_ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

`ifdef FRAME_WRITER_SOF_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WRITE,
        DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic [IDX_W-1:0]          word_index_reg, word_index_next;
    logic [7:0]                low_byte_reg, low_byte_next;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [15:0]               mem_wdata_reg, mem_wdata_next;
    logic                      mem_we_reg, mem_we_next;
    logic                      frame_done_reg, frame_done_next;
    logic                      rd_bank_reg, rd_bank_next;
    logic                      accept;
    logic                      restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            word_index_reg <= '0;
            low_byte_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            rd_bank_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_index_reg <= word_index_next;
            low_byte_reg   <= low_byte_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_we_reg     <= mem_we_next;
            frame_done_reg <= frame_done_next;
            rd_bank_reg    <= rd_bank_next;
        end
    end

    assign in_ready = (state_reg == IDLE) || (state_reg == LOW) || (state_reg == HIGH);
    assign accept   = in_valid && in_ready;
    // Mid-frame sof only matters when resynchronisation is compiled in.
    assign restart  = RESYNC && accept && in_sof;

    always_comb begin
        state_next      = state_reg;
        word_index_next = word_index_reg;
        low_byte_next   = low_byte_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_we_next     = mem_we_reg;
        frame_done_next = 1'b0;
        rd_bank_next    = rd_bank_reg;

        case (state_reg)
            IDLE: begin
                if (accept && in_sof) begin
                    low_byte_next   = in_data;
                    word_index_next = '0;
                    state_next      = HIGH;
                end
            end
            LOW: begin
                if (accept) begin
                    if (restart) begin
                        word_index_next = '0;
                    end
                    low_byte_next = in_data;
                    state_next    = HIGH;
                end
            end
            HIGH: begin
                if (restart) begin
                    low_byte_next   = in_data;
                    word_index_next = '0;
                end else if (accept) begin
                    mem_wdata_next = {in_data, low_byte_reg};
                    mem_addr_next  = {~rd_bank_reg, word_index_reg};
                    mem_we_next    = 1'b1;
                    state_next     = WRITE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    mem_we_next = 1'b0;
                    if (word_index_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        word_index_next = word_index_reg + 1'b1;
                        state_next      = LOW;
                    end
                end
            end
            DONE: begin
                frame_done_next = 1'b1;
                rd_bank_next    = ~rd_bank_reg;
                word_index_next = '0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_we     = mem_we_reg;
    assign frame_done = frame_done_reg;
    assign rd_bank    = rd_bank_reg;

endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side counterpart of the memory address generator. Accepts the incoming pixel byte stream from the host interface, packs byte pairs into 16-bit words, and issues sequential memory write requests into the back buffer of a double-buffered frame store. At the end of each complete frame it swaps banks, so the read-side address generator always scans the most recently completed frame.

## Interface
- MEM_ADDR_WIDTH, 24, memory address width; MSB selects the bank.
- FRAME_WORDS, 4096, 16-bit words per frame; must be ≥2 and ≤ 2^(MEM_ADDR_WIDTH-1).

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  pixel byte.
- in_valid  in  1  in_data is valid.
- in_sof  in  1  start of frame; qualified by in_valid, marks the first byte of a frame.
- in_ready  out  1  byte accepted on a cycle where in_valid && in_ready.
- mem_addr  out  MEM_ADDR_WIDTH  write address: {wr_bank, zero-extended word_index}.
- mem_wdata  out  16  write data; first byte in [7:0], second byte in [15:8].
- mem_we  out  1  write request; held until acknowledged.
- mem_ack  in  1  memory accepted the write this cycle.
- frame_done  out  1  one-cycle pulse when a frame completes.
- rd_bank  out  1  bank holding the last completed frame. The write bank is always ~rd_bank.

## Operation
- States: IDLE, LOW, HIGH, WRITE, DONE.
- in_ready is 1 in IDLE, LOW and HIGH, and 0 in WRITE and DONE. It is decoded combinationally from the state register.
- IDLE: accepted bytes without in_sof are discarded. An accepted byte with in_sof is stored as the low byte; word_index←0; go to HIGH.
- LOW: an accepted byte is stored as the low byte; go to HIGH.
- HIGH: an accepted byte is stored as the high byte; mem_wdata, mem_addr and mem_we←1 are registered; go to WRITE.
- WRITE: mem_addr, mem_wdata and mem_we are held stable until mem_ack=1.
  - On the ack cycle, mem_we←0.
  - If word_index == FRAME_WORDS-1, go to DONE.
  - Otherwise word_index←word_index+1 and go to LOW.
- DONE (single cycle): frame_done←1, rd_bank←~rd_bank, word_index←0; go to IDLE.
- in_sof in LOW or HIGH: behaviour is set by the macro under Configuration.
- mem_ack outside WRITE is ignored.
- word_index never exceeds FRAME_WORDS-1. No wrap-around writes occur; the frame terminates instead.

## Timing
- Reset values: state IDLE, in_ready 1 (decoded from IDLE), mem_we 0, mem_addr 0, mem_wdata 0, frame_done 0, rd_bank 0, word_index 0. Writes after reset therefore go to bank 1.
- Reset asserted mid-frame aborts the frame: no bank swap, no frame_done, and mem_we drops on the next edge.
- Latency: mem_we rises on the edge that accepts the high byte. The earliest ack is in that same following cycle, which is the first WRITE cycle.
- Peak throughput: one word per 3 cycles (LOW, HIGH, WRITE) with zero-wait ack.
- frame_done and the rd_bank toggle take effect on the same edge, one cycle after the ack of the final word.
- Simultaneous mem_ack and in_valid in WRITE: the byte is not accepted (in_ready=0). The source must hold it.

## Configuration
- FRAME_WRITER_SOF_RESYNC_EN defined: an accepted byte with in_sof in LOW or HIGH restarts the frame.
  - word_index←0.
  - The byte becomes the low byte; go to HIGH.
  - No bank swap; already-written words of the back buffer are simply overwritten.
- Not defined: in_sof outside IDLE is ignored, and the byte is treated as ordinary data.

## Test plan
All scenarios use FRAME_WORDS=4.
- Reset, then bytes 0x11,0x22 (first with sof) and ack held 1 -> one write, mem_addr=0x800000, mem_wdata=0x2211, mem_we high exactly 1 cycle.
- Full frame of 8 bytes with ack always 1 -> four writes to 0x800000..0x800003, then frame_done pulse; rd_bank 0→1. A second frame writes 0x000000..0x000003, then rd_bank→0.
- ack delayed 3 cycles on word 1 -> mem_addr and mem_wdata stable for 4 cycles, in_ready=0 throughout, no byte lost.
- Bytes without sof while IDLE -> no mem_we, word_index stays 0. A following sof byte starts the frame at offset 0.
- sof after 3 bytes -> with FRAME_WRITER_SOF_RESYNC_EN, the next write goes to offset 0 with the new bytes. Without it, the byte is written as the high byte of word 1 at offset 1.
- rst pulsed while in WRITE on word 2 -> mem_we=0 next cycle, rd_bank=0, no frame_done. The next sof frame writes into bank 1 from offset 0.
